// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the program loader and its helpers.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_COUNT = 3'd1,
    ST_HI    = 3'd2,
    ST_LO    = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_RUN   = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam int         MAX_WORDS = 64;
  localparam logic [7:0] CHK_INIT  = 8'h00;

  // States in which the loader is waiting on the byte source.
  function automatic logic waits_for_byte(input state_e s);
    return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
  endfunction

  function automatic logic is_busy(input state_e s);
    return waits_for_byte(s) || (s == ST_WRITE);
  endfunction

endpackage

// File: rtl/prog_loader_timeout.sv
// Idle-cycle counter with clear/enable; flags the cycle in which LIMIT idle cycles are reached.
module loader_timeout #(
  parameter int LIMIT = 1024,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // A clear in the same cycle means activity, so it suppresses expiry.
  assign expired_o = en_i && !clr_i && (cnt_q == W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !expired_o)
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses COUNT/data/CHK frames, writes instruction memory,
// and holds the core in reset until a checksum-verified load completes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DEPTH   = MAX_WORDS,
  parameter int TIMEOUT = 1024
) (
  input  logic              clka,
  input  logic              reset,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [15:0]       load,
  output logic [ADDR_W-1:0] ins_addr,
  output logic              we_ins,
  output logic              cpu_hold,
  output logic              busy,
  output logic              error,
  output logic [6:0]        words_loaded
);

  state_e              state_q, state_d;
  logic [15:0]         load_q, load_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [6:0]          words_q, words_d;
  logic [6:0]          n_q, n_d;
  logic [7:0]          chk_q, chk_d;
  logic                we_q, we_d;
  logic                rdy_q, hold_q, busy_q, err_q;
  logic                xfer, tmo, count_ok;

  // load_start wins over a simultaneous byte, so the source must not see a handshake.
  assign byte_ready = rdy_q && !load_start;
  assign xfer       = byte_valid && byte_ready;
  assign count_ok   = (byte_data != 8'd0) && (int'(byte_data) <= DEPTH);

  loader_timeout #(.LIMIT(TIMEOUT)) u_timeout (
    .clk_i     (clka),
    .rst_ni    (reset),
    .clr_i     (xfer || load_start || !waits_for_byte(state_q)),
    .en_i      (waits_for_byte(state_q)),
    .expired_o (tmo)
  );

  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    addr_d  = addr_q;
    words_d = words_q;
    n_d     = n_q;
    chk_d   = chk_q;
    we_d    = 1'b0;
    if (load_start) begin
      state_d = ST_COUNT;
    end else begin
      case (state_q)
        ST_COUNT: begin
          if (xfer) begin
            if (count_ok) begin
              n_d     = byte_data[6:0];
              chk_d   = CHK_INIT;
              addr_d  = '0;
              words_d = '0;
              state_d = ST_HI;
            end else begin
              state_d = ST_ERR;
            end
          end else if (tmo) begin
            state_d = ST_ERR;
          end
        end
        ST_HI: begin
          if (xfer) begin
            load_d[15:8] = byte_data;
            chk_d        = chk_q ^ byte_data;
            state_d      = ST_LO;
          end else if (tmo) begin
            state_d = ST_ERR;
          end
        end
        ST_LO: begin
          if (xfer) begin
            load_d[7:0] = byte_data;
            chk_d       = chk_q ^ byte_data;
            we_d        = 1'b1;
            state_d     = ST_WRITE;
          end else if (tmo) begin
            state_d = ST_ERR;
          end
        end
        ST_WRITE: begin
          // Address wraps after word 63; harmless because the frame ends there.
          addr_d  = addr_q + ADDR_W'(1);
          words_d = words_q + 7'd1;
          state_d = (words_q + 7'd1 == n_q) ? ST_CSUM : ST_HI;
        end
        ST_CSUM: begin
          if (xfer)
            state_d = (byte_data == chk_q) ? ST_RUN : ST_ERR;
          else if (tmo)
            state_d = ST_ERR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      load_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      n_q     <= '0;
      chk_q   <= CHK_INIT;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      n_q     <= n_d;
      chk_q   <= chk_d;
      we_q    <= we_d;
      rdy_q   <= waits_for_byte(state_d);
      hold_q  <= (state_d != ST_RUN);
      busy_q  <= is_busy(state_d);
      err_q   <= (state_d == ST_ERR);
    end
  end

  assign load         = load_q;
  assign ins_addr     = addr_q;
  assign we_ins       = we_q;
  assign cpu_hold     = hold_q;
  assign busy         = busy_q;
  assign error        = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: frame table plus hand-written abort, timeout and reset sequences.
module tb_prog_loader;

  logic        clka = 1'b0;
  logic        reset;
  logic        load_start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [15:0] load;
  logic [5:0]  ins_addr;
  logic        we_ins;
  logic        cpu_hold;
  logic        busy;
  logic        error;
  logic [6:0]  words_loaded;

  int n_checks = 0;
  int n_errors = 0;

  logic [21:0] exp_q[$];
  logic [21:0] mon_exp;
  logic [15:0] wbuf[64];

  typedef struct packed {
    logic [7:0]  cnt;
    logic [1:0]  nw;
    logic [47:0] words;
    logic [7:0]  chk_xor;
    logic        exp_err;
    logic        exp_hold;
    logic [6:0]  exp_words;
  } vec_t;

  vec_t vecs[7];

  prog_loader #(.ADDR_W(6), .DEPTH(64), .TIMEOUT(8)) dut (
    .clka         (clka),
    .reset        (reset),
    .load_start   (load_start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .load         (load),
    .ins_addr     (ins_addr),
    .we_ins       (we_ins),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clka = ~clka;

  // Every write strobe must match the next expected (addr, word) pair.
  always @(negedge clka) begin
    if (reset && we_ins) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL write_unexp: got addr %0d data %h, required no write", ins_addr, load);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({ins_addr, load} !== mon_exp) begin
          n_errors++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   ins_addr, load, mon_exp[21:16], mon_exp[15:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clka);
      if (byte_ready) begin
        @(posedge clka);
        #1;
        done = 1'b1;
      end
    end
    byte_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL byte_accept: byte %h not accepted, required acceptance within 32 cycles", b);
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clka);
    #1;
    load_start = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cnt, input int nw, input logic [7:0] chk_xor);
    logic [7:0] c = 8'h00;
    pulse_start();
    send_byte(cnt);
    if (nw > 0) begin
      for (int i = 0; i < nw; i++) begin
        send_byte(wbuf[i][15:8]);
        send_byte(wbuf[i][7:0]);
        exp_q.push_back({6'(i), wbuf[i]});
        c = c ^ wbuf[i][15:8] ^ wbuf[i][7:0];
      end
      send_byte(c ^ chk_xor);
    end
    repeat (3) @(posedge clka);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
    check({tag, "_we_ins"}, we_ins, 0);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_words"}, words_loaded, 0);
    check({tag, "_load"}, load, 0);
    check({tag, "_ins_addr"}, ins_addr, 0);
  endtask

  initial begin
    vecs[0] = '{8'd2,    2'd2, 48'h0000_ABCD_1234, 8'h00, 1'b0, 1'b0, 7'd2};
    vecs[1] = '{8'd2,    2'd2, 48'h0000_ABCD_1234, 8'h01, 1'b1, 1'b1, 7'd2};
    vecs[2] = '{8'd0,    2'd0, 48'h0,              8'h00, 1'b1, 1'b1, 7'd2};
    vecs[3] = '{8'h41,   2'd0, 48'h0,              8'h00, 1'b1, 1'b1, 7'd2};
    vecs[4] = '{8'd1,    2'd1, 48'h0000_0000_5A5A, 8'h00, 1'b0, 1'b0, 7'd1};
    vecs[5] = '{8'd3,    2'd3, 48'hFFFF_0000_8001, 8'h00, 1'b0, 1'b0, 7'd3};
    vecs[6] = '{8'd3,    2'd3, 48'h0F0F_7E7E_C001, 8'h80, 1'b1, 1'b1, 7'd3};

    reset      = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clka);
    #1;
    check_reset_outputs("rst");
    @(negedge clka);
    reset = 1'b1;
    @(posedge clka);
    #1;

    // IDLE ignores a waiting source.
    byte_valid = 1'b1;
    byte_data  = 8'h02;
    repeat (3) @(posedge clka);
    #1;
    check("idle_byte_ready", byte_ready, 0);
    check("idle_busy", busy, 0);
    byte_valid = 1'b0;

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 3; j++) wbuf[j] = vecs[i].words[16*j +: 16];
      send_frame(vecs[i].cnt, int'(vecs[i].nw), vecs[i].chk_xor);
      check($sformatf("vec%0d_error", i), error, vecs[i].exp_err);
      check($sformatf("vec%0d_cpu_hold", i), cpu_hold, vecs[i].exp_hold);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_words", i), words_loaded, vecs[i].exp_words);
    end

    // Abort after the HI byte of word 0, with a byte offered alongside load_start.
    pulse_start();
    send_byte(8'd2);
    send_byte(8'h77);
    load_start = 1'b1;
    byte_valid = 1'b1;
    byte_data  = 8'h88;
    #1;
    check("abort_rdy_during_start", byte_ready, 0);
    @(posedge clka);
    #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
    check("abort_busy", busy, 1);
    check("abort_cpu_hold", cpu_hold, 1);
    send_byte(8'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    exp_q.push_back({6'd0, 16'h0102});
    send_byte(8'h03);
    repeat (3) @(posedge clka);
    #1;
    check("abort_error", error, 0);
    check("abort_cpu_hold_run", cpu_hold, 0);
    check("abort_words", words_loaded, 1);
    check("abort_ins_addr", ins_addr, 1);

    // Stall in LO: seven idle cycles are tolerated, the eighth aborts.
    pulse_start();
    send_byte(8'd1);
    send_byte(8'h11);
    repeat (7) @(posedge clka);
    #1;
    check("tmo_error_before", error, 0);
    check("tmo_busy_before", busy, 1);
    @(posedge clka);
    #1;
    check("tmo_error_at", error, 1);
    check("tmo_busy_at", busy, 0);
    check("tmo_cpu_hold", cpu_hold, 1);

    // Full 64-word program: addresses 0..63.
    for (int i = 0; i < 64; i++) wbuf[i] = 16'($urandom);
    send_frame(8'd64, 64, 8'h00);
    check("n64_error", error, 0);
    check("n64_cpu_hold", cpu_hold, 0);
    check("n64_words", words_loaded, 64);

    // Asynchronous reset mid-frame with the source still presenting a byte.
    pulse_start();
    send_byte(8'd2);
    send_byte(8'hC3);
    send_byte(8'h3C);
    exp_q.push_back({6'd0, 16'hC33C});
    send_byte(8'h99);
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(negedge clka);
    reset = 1'b1;
    repeat (4) @(posedge clka);
    #1;
    check("arst_post_byte_ready", byte_ready, 0);
    check("arst_post_busy", busy, 0);
    check("arst_post_cpu_hold", cpu_hold, 1);
    byte_valid = 1'b0;

    wbuf[0] = 16'hBEEF;
    send_frame(8'd1, 1, 8'h00);
    check("recover_error", error, 0);
    check("recover_cpu_hold", cpu_hold, 0);
    check("recover_words", words_loaded, 1);

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
